// File: rtl/link_rr_arbiter.sv
// -----------------------------------------------------------------------------
// link_rr_arbiter
//   Shares one output link among NUM_IN showahead input FIFOs. Arbitration is
//   round-robin with packet lock: a FIFO that sends a non-tail flit keeps the
//   link until its tail flit has gone out. Credit-based flow control stops the
//   arbiter from sending more flits than the downstream buffer can hold.
//
// Ports
//   clk           : clock, all logic on posedge
//   rst           : synchronous, active-high reset
//   buf_empty     : per-FIFO empty flag
//   buf_out       : per-FIFO head flit, FIFO i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//   buf_consume   : per-FIFO pop strobe (combinational, one-hot or zero)
//   out_valid     : registered, out_data holds a flit this cycle
//   out_data      : registered flit to the link (holds when out_valid=0)
//   grant_id      : registered index of the FIFO that sourced out_data
//   credit_return : downstream freed one slot this cycle
//   credits       : current credit count
//   credit_err    : sticky, credit returned while already at CREDIT_MAX
// -----------------------------------------------------------------------------
module link_rr_arbiter #(
  parameter int NUM_IN       = 4,
  parameter int FLIT_WIDTH   = 64,
  parameter int CREDIT_MAX   = 8,
  parameter int CREDIT_WIDTH = 4,
  parameter int ID_WIDTH     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            buf_empty,
  input  logic [NUM_IN*FLIT_WIDTH-1:0] buf_out,
  output logic [NUM_IN-1:0]            buf_consume,
  output logic                         out_valid,
  output logic [FLIT_WIDTH-1:0]        out_data,
  output logic [ID_WIDTH-1:0]          grant_id,
  input  logic                         credit_return,
  output logic [CREDIT_WIDTH-1:0]      credits,
  output logic                         credit_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(CREDIT_MAX);

  state_t                  state_reg, state_next;
  logic [ID_WIDTH-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [ID_WIDTH-1:0]     owner_reg, owner_next;
  logic [CREDIT_WIDTH-1:0] credits_reg, credits_next;
  logic                    credit_err_reg, credit_err_next;
  logic                    out_valid_reg;
  logic [FLIT_WIDTH-1:0]   out_data_reg;
  logic [ID_WIDTH-1:0]     grant_id_reg;

  logic [FLIT_WIDTH-1:0]   flit [NUM_IN];
  logic [ID_WIDTH-1:0]     cand_idx [NUM_IN];
  logic [ID_WIDTH-1:0]     winner;
  logic [ID_WIDTH-1:0]     sel;
  logic [NUM_IN-1:0]       consume;
  logic                    send;
  logic                    any_req;
  logic                    has_credit;

  // Unpack head flits and build the round-robin scan order: cand_idx[k] is
  // (rr_ptr + k) mod NUM_IN, so cand_idx[0] has the highest priority.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_in
      logic [ID_WIDTH:0] sum;
      assign flit[gi]     = buf_out[gi*FLIT_WIDTH +: FLIT_WIDTH];
      assign sum          = {1'b0, rr_ptr_reg} + (ID_WIDTH+1)'(gi);
      assign cand_idx[gi] = (sum >= (ID_WIDTH+1)'(NUM_IN))
                            ? ID_WIDTH'(sum - (ID_WIDTH+1)'(NUM_IN))
                            : sum[ID_WIDTH-1:0];
    end
  endgenerate

  function automatic logic [ID_WIDTH-1:0] next_idx(input logic [ID_WIDTH-1:0] v);
    return (v == ID_WIDTH'(NUM_IN-1)) ? '0 : v + ID_WIDTH'(1);
  endfunction

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    winner = cand_idx[0];
    for (int k = NUM_IN-1; k >= 0; k--) begin
      if (!buf_empty[cand_idx[k]]) winner = cand_idx[k];
    end
  end

  assign any_req    = ~&buf_empty;
  assign has_credit = (credits_reg != '0);

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    rr_ptr_next = rr_ptr_reg;
    consume     = '0;
    send        = 1'b0;
    sel         = owner_reg;
    case (state_reg)
      IDLE: begin
        sel = winner;
        if (has_credit && any_req) begin
          send            = 1'b1;
          consume[winner] = 1'b1;
          if (flit[winner][FLIT_WIDTH-1]) begin
            rr_ptr_next = next_idx(winner);
          end else begin
            state_next = LOCKED;
            owner_next = winner;
          end
        end
      end
      LOCKED: begin
        // Other FIFOs are ignored until the owner's tail flit goes out.
        if (has_credit && !buf_empty[owner_reg]) begin
          send               = 1'b1;
          consume[owner_reg] = 1'b1;
          if (flit[owner_reg][FLIT_WIDTH-1]) begin
            state_next  = IDLE;
            rr_ptr_next = next_idx(owner_reg);
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      consume = '0;
      send    = 1'b0;
    end
  end

  // A credit returned in the same cycle as a send cancels out; a return with
  // no send saturates at CREDIT_MAX and flags the overflow.
  always_comb begin
    credits_next = credits_reg;
    if (send && !credit_return) begin
      credits_next = credits_reg - CREDIT_WIDTH'(1);
    end else if (!send && credit_return && (credits_reg != CREDIT_FULL)) begin
      credits_next = credits_reg + CREDIT_WIDTH'(1);
    end
    credit_err_next = credit_err_reg |
                      (credit_return && !send && (credits_reg == CREDIT_FULL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      owner_reg      <= '0;
      credits_reg    <= CREDIT_FULL;
      credit_err_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      grant_id_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      owner_reg      <= owner_next;
      credits_reg    <= credits_next;
      credit_err_reg <= credit_err_next;
      out_valid_reg  <= send;
      if (send) begin
        out_data_reg <= flit[sel];
        grant_id_reg <= sel;
      end
    end
  end

  assign buf_consume = consume;
  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign grant_id    = grant_id_reg;
  assign credits     = credits_reg;
  assign credit_err  = credit_err_reg;

endmodule

// File: tb/tb_link_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_link_rr_arbiter
//   Directed bench for link_rr_arbiter. Four small FIFO models feed the DUT;
//   each scenario task drives stimulus and compares outputs against
//   hand-computed values.
// -----------------------------------------------------------------------------
module tb_link_rr_arbiter;

  localparam int NUM_IN = 4;
  localparam int FW     = 64;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_IN-1:0] buf_empty;
  logic [NUM_IN*FW-1:0] buf_out;
  logic [NUM_IN-1:0] buf_consume;
  logic              out_valid;
  logic [FW-1:0]     out_data;
  logic [1:0]        grant_id;
  logic              credit_return = 1'b0;
  logic [3:0]        credits;
  logic              credit_err;

  logic [FW-1:0] fifo_mem [NUM_IN][DEPTH];
  int            rd_ptr [NUM_IN];
  int            wr_ptr [NUM_IN];

  int n_checks = 0;
  int n_pass   = 0;

  link_rr_arbiter #(
    .NUM_IN(4), .FLIT_WIDTH(64), .CREDIT_MAX(8), .CREDIT_WIDTH(4), .ID_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .buf_empty(buf_empty), .buf_out(buf_out),
    .buf_consume(buf_consume), .out_valid(out_valid), .out_data(out_data),
    .grant_id(grant_id), .credit_return(credit_return), .credits(credits),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic tail, input logic [15:0] d);
    return {tail, 47'd0, d};
  endfunction

  task automatic refresh();
    for (int i = 0; i < NUM_IN; i++) begin
      buf_empty[i] = (rd_ptr[i] == wr_ptr[i]);
      buf_out[i*FW +: FW] = buf_empty[i] ? '0 : fifo_mem[i][rd_ptr[i]];
    end
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NUM_IN; i++) begin
      rd_ptr[i] = 0;
      wr_ptr[i] = 0;
    end
    refresh();
  endtask

  task automatic push(input int i, input logic [FW-1:0] d);
    fifo_mem[i][wr_ptr[i]] = d;
    wr_ptr[i]++;
    refresh();
  endtask

  // One clock: sample the pop strobes before the edge, then pop after it.
  task automatic tick();
    logic [NUM_IN-1:0] cons;
    #1;
    cons = buf_consume;
    n_checks++;
    if ((cons & buf_empty) !== '0)
      $display("FAIL consume_on_empty: consume=%b empty=%b required no overlap", cons, buf_empty);
    else n_pass++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (cons[i]) begin
        $display("xfer t=%0t fifo=%0d flit=%h credits_before_edge_consumed", $time, i, fifo_mem[i][rd_ptr[i]]);
        rd_ptr[i]++;
      end
    end
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    credit_return = 1'b0;
    clear_fifos();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_fifos();
    push(0, mk(1'b1, 16'h00A1));
    #1;
    n_checks++; if (buf_consume !== 4'b0000) $display("FAIL rst_consume: got %b want 0000", buf_consume); else n_pass++;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL rst_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (grant_id !== 2'd0) $display("FAIL rst_grant: got %0d want 0", grant_id); else n_pass++;
    n_checks++; if (credits !== 4'd8) $display("FAIL rst_credits: got %0d want 8", credits); else n_pass++;
    n_checks++; if (credit_err !== 1'b0) $display("FAIL rst_err: got %b want 0", credit_err); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (buf_consume !== 4'b0001) $display("FAIL single_consume: got %b want 0001", buf_consume); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== mk(1'b1, 16'h00A1)) $display("FAIL single_data: got %h want %h", out_data, mk(1'b1, 16'h00A1)); else n_pass++;
    n_checks++; if (grant_id !== 2'd0) $display("FAIL single_grant: got %0d want 0", grant_id); else n_pass++;
    n_checks++; if (credits !== 4'd7) $display("FAIL single_credits: got %0d want 7", credits); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL idle_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== mk(1'b1, 16'h00A1)) $display("FAIL hold_data: got %h want %h", out_data, mk(1'b1, 16'h00A1)); else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NUM_IN; i++) push(i, mk(1'b1, 16'h00B0 + 16'(i)));
    credit_return = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1) $display("FAIL rr_valid%0d: got %b want 1", k, out_valid); else n_pass++;
      n_checks++; if (grant_id !== 2'(k)) $display("FAIL rr_grant%0d: got %0d want %0d", k, grant_id, k); else n_pass++;
      n_checks++; if (out_data !== mk(1'b1, 16'h00B0 + 16'(k))) $display("FAIL rr_data%0d: got %h", k, out_data); else n_pass++;
      n_checks++; if (credits !== 4'd8) $display("FAIL rr_credits%0d: got %0d want 8", k, credits); else n_pass++;
    end
    credit_return = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rr_drain_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (credit_err !== 1'b0) $display("FAIL rr_err: got %b want 0", credit_err); else n_pass++;
  endtask

  task automatic test_packet_lock();
    do_reset();
    push(1, mk(1'b0, 16'h00A0));
    push(1, mk(1'b0, 16'h00A1));
    push(1, mk(1'b1, 16'h00A2));
    tick();
    n_checks++; if (grant_id !== 2'd1 || out_data !== mk(1'b0, 16'h00A0)) $display("FAIL lock_f1: got id=%0d data=%h want id=1 data=%h", grant_id, out_data, mk(1'b0, 16'h00A0)); else n_pass++;
    push(0, mk(1'b1, 16'h00F0));
    #1;
    n_checks++; if (buf_consume !== 4'b0010) $display("FAIL lock_consume: got %b want 0010", buf_consume); else n_pass++;
    tick();
    n_checks++; if (grant_id !== 2'd1 || out_data !== mk(1'b0, 16'h00A1)) $display("FAIL lock_f2: got id=%0d data=%h want id=1 data=%h", grant_id, out_data, mk(1'b0, 16'h00A1)); else n_pass++;
    tick();
    n_checks++; if (grant_id !== 2'd1 || out_data !== mk(1'b1, 16'h00A2)) $display("FAIL lock_f3: got id=%0d data=%h want id=1 data=%h", grant_id, out_data, mk(1'b1, 16'h00A2)); else n_pass++;
    // rr_ptr must now be 2, so FIFO0 beats a newly filled FIFO1.
    push(1, mk(1'b1, 16'h00C0));
    #1;
    n_checks++; if (buf_consume !== 4'b0001) $display("FAIL lock_next_consume: got %b want 0001", buf_consume); else n_pass++;
    tick();
    n_checks++; if (grant_id !== 2'd0 || out_data !== mk(1'b1, 16'h00F0)) $display("FAIL lock_next: got id=%0d data=%h want id=0", grant_id, out_data); else n_pass++;
    tick();
    n_checks++; if (grant_id !== 2'd1 || out_data !== mk(1'b1, 16'h00C0)) $display("FAIL lock_after: got id=%0d data=%h want id=1", grant_id, out_data); else n_pass++;
    n_checks++; if (credits !== 4'd3) $display("FAIL lock_credits: got %0d want 3", credits); else n_pass++;
  endtask

  task automatic test_credit_stall();
    int sends;
    do_reset();
    for (int j = 0; j < 10; j++) push(2, mk(1'b1, 16'h00D0 + 16'(j)));
    sends = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (out_valid === 1'b1 && out_data === mk(1'b1, 16'h00D0 + 16'(j))) sends++;
    end
    n_checks++; if (sends !== 8) $display("FAIL credit_sends: got %0d want 8", sends); else n_pass++;
    n_checks++; if (credits !== 4'd0) $display("FAIL credit_zero: got %0d want 0", credits); else n_pass++;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL credit_stall: got %b want 0", out_valid); else n_pass++;
    credit_return = 1'b1;
    #1;
    n_checks++; if (buf_consume !== 4'b0000) $display("FAIL credit_block: got %b want 0000", buf_consume); else n_pass++;
    tick();
    credit_return = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || credits !== 4'd1) $display("FAIL credit_return: got valid=%b credits=%0d want 0/1", out_valid, credits); else n_pass++;
    #1;
    n_checks++; if (buf_consume !== 4'b0100) $display("FAIL credit_resume: got %b want 0100", buf_consume); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== mk(1'b1, 16'h00D8) || credits !== 4'd0) $display("FAIL credit_one_more: got valid=%b data=%h credits=%0d", out_valid, out_data, credits); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL credit_only_one: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    push(3, mk(1'b0, 16'h00E0));
    push(3, mk(1'b0, 16'h00E1));
    push(3, mk(1'b1, 16'h00E2));
    tick();
    n_checks++; if (grant_id !== 2'd3 || out_valid !== 1'b1) $display("FAIL mid_lock: got id=%0d valid=%b want 3/1", grant_id, out_valid); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (buf_consume !== 4'b0000) $display("FAIL mid_rst_consume: got %b want 0000", buf_consume); else n_pass++;
    tick();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || credits !== 4'd8) $display("FAIL mid_rst_state: got valid=%b credits=%0d want 0/8", out_valid, credits); else n_pass++;
    push(0, mk(1'b1, 16'h0050));
    #1;
    n_checks++; if (buf_consume !== 4'b0001) $display("FAIL mid_consume: got %b want 0001", buf_consume); else n_pass++;
    tick();
    n_checks++; if (grant_id !== 2'd0 || out_data !== mk(1'b1, 16'h0050)) $display("FAIL mid_grant0: got id=%0d data=%h want 0", grant_id, out_data); else n_pass++;
    tick();
    n_checks++; if (grant_id !== 2'd3 || out_data !== mk(1'b0, 16'h00E1)) $display("FAIL mid_grant3: got id=%0d data=%h want 3", grant_id, out_data); else n_pass++;
  endtask

  task automatic test_credit_err();
    do_reset();
    n_checks++; if (credit_err !== 1'b0) $display("FAIL err_init: got %b want 0", credit_err); else n_pass++;
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    n_checks++; if (credits !== 4'd8 || credit_err !== 1'b1) $display("FAIL err_set: got credits=%0d err=%b want 8/1", credits, credit_err); else n_pass++;
    tick();
    tick();
    n_checks++; if (credit_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", credit_err); else n_pass++;
    do_reset();
    n_checks++; if (credit_err !== 1'b0) $display("FAIL err_clear: got %b want 0", credit_err); else n_pass++;
  endtask

  initial begin
    clear_fifos();
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_credit_stall();
    test_reset_mid_packet();
    test_credit_err();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
